// File: rtl/otter_intr_csr_pkg.sv
// Shared constants and types for the OTTER machine-mode interrupt/CSR unit.
// Holds CSR addresses, mstatus bit positions and the external-interrupt cause code.
package otter_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

    // mtvec and mepc are word aligned; the two low bits always read 0.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/otter_intr_csr_irq_edge_sync.sv
// External interrupt conditioning: optional 2-flop synchronizer, then rising-edge detect.
// Ports: clk, RST (sync, active-high), ext_irq in; irq_rise out (one-cycle pulse per 0->1).
// OTTER_IRQ_SYNC_EN defined: sync1 -> sync2 -> history flop ahead of the edge detector.
// OTTER_IRQ_SYNC_EN undefined: ext_irq assumed synchronous; a single history flop.
module irq_edge_sync (
    input  logic clk,
    input  logic RST,
    input  logic ext_irq,
    output logic irq_rise
);

    logic level;
    logic hist_d;
    logic hist_q;

`ifdef OTTER_IRQ_SYNC_EN
    logic sync1_d;
    logic sync1_q;
    logic sync2_d;
    logic sync2_q;

    always_comb begin
        sync1_d = ext_irq;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign level = sync2_q;
`else
    assign level = ext_irq;
`endif

    always_comb begin
        hist_d = level;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign irq_rise = level & ~hist_q;

endmodule

// File: rtl/otter_intr_csr.sv
// Machine-mode interrupt controller and CSR file (mstatus, mtvec, mepc, mcause).
// Ports: clk, RST, ext_irq, csr_we/csr_addr/csr_wd, int_taken, mret_exec, pc in;
//        csr_rd, intr, mtvec, mepc, mie out. Synchronizer enabled by OTTER_IRQ_SYNC_EN.
module otter_intr_csr
    import otter_pkg::*;
(
    input  logic        clk,
    input  logic        RST,
    input  logic        ext_irq,
    input  logic        csr_we,
    input  csr_addr_t   csr_addr,
    input  logic [31:0] csr_wd,
    input  logic        int_taken,
    input  logic        mret_exec,
    input  logic [31:0] pc,
    output logic [31:0] csr_rd,
    output logic        intr,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        mie
);

    logic        irq_rise;

    logic        pending_d, pending_q;
    logic        mie_d, mie_q;
    logic        mpie_d, mpie_q;
    logic [31:0] mtvec_d, mtvec_q;
    logic [31:0] mepc_d, mepc_q;
    logic [31:0] mcause_d, mcause_q;

    logic        wr_mstatus;
    logic        wr_mtvec;
    logic        wr_mepc;
    logic        wr_mcause;

    irq_edge_sync u_irq_edge_sync (
        .clk      (clk),
        .RST      (RST),
        .ext_irq  (ext_irq),
        .irq_rise (irq_rise)
    );

    always_comb begin
        wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
        wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
        wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
        wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE);
    end

    always_comb begin
        pending_d = pending_q | irq_rise;
        mie_d     = mie_q;
        mpie_d    = mpie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;

        if (int_taken) begin
            // An edge arriving in the same cycle as entry survives.
            pending_d = irq_rise;
            mpie_d    = mie_q;
            mie_d     = 1'b0;
            mepc_d    = pc & WORD_ALIGN_MASK;
            mcause_d  = MCAUSE_EXT_IRQ;
        end else if (mret_exec) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            mie_d  = csr_wd[MSTATUS_MIE_BIT];
            mpie_d = csr_wd[MSTATUS_MPIE_BIT];
        end

        // mtvec is never touched by trap entry or mret.
        if (wr_mtvec) begin
            mtvec_d = csr_wd & WORD_ALIGN_MASK;
        end

        if (!int_taken && wr_mepc) begin
            mepc_d = csr_wd & WORD_ALIGN_MASK;
        end

        if (!int_taken && wr_mcause) begin
            mcause_d = csr_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pending_q <= 1'b0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            pending_q <= pending_d;
            mie_q     <= mie_d;
            mpie_q    <= mpie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    always_comb begin
        csr_rd = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rd[MSTATUS_MIE_BIT]  = mie_q;
                csr_rd[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MTVEC:  csr_rd = mtvec_q;
            CSR_MEPC:   csr_rd = mepc_q;
            CSR_MCAUSE: csr_rd = mcause_q;
            default:    csr_rd = '0;
        endcase
    end

    assign intr  = pending_q & mie_q;
    assign mtvec = mtvec_q;
    assign mepc  = mepc_q;
    assign mie   = mie_q;

`ifndef SYNTHESIS
    // The FSM must never enter a trap and return from one in the same cycle.
    a_no_take_and_mret: assert property (
        @(posedge clk) disable iff (RST) !(int_taken && mret_exec)
    );
`endif

endmodule
